// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle logic/arith/branch ops, iterative shift/rotate
// and shift-add multiply, valid/ready on both sides, registered result and flags.
module alu_seq #(
  parameter int W   = 8,
  parameter int SHW = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         zero,
  output logic         neg,
  output logic         carry,
  output logic         taken,
  output logic         err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SRL  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_XORR = 4'd7;
  localparam logic [3:0] OP_BEQ  = 4'd8;
  localparam logic [3:0] OP_BNE  = 4'd9;
  localparam logic [3:0] OP_BLT  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;
  localparam logic [3:0] OP_ROL  = 4'd12;
  localparam logic [3:0] OP_ROR  = 4'd13;

  logic [1:0]   state;
  logic [3:0]   cur_op;
  logic [W-1:0] lo, hi, mcand;
  logic [SHW:0] cnt;

  logic [W:0]   sum_ab;
  logic [W-1:0] diff;
  logic [W-1:0] r1;
  logic         c1, t1, e1, multi;

  logic [W:0]   step_sum;
  logic [W-1:0] step_val, step_hi;

  assign sum_ab = {1'b0, a} + {1'b0, b};
  assign diff   = a - b;
  assign multi  = (op == OP_SRL) || (op == OP_SLL) || (op == OP_ROL) ||
                  (op == OP_ROR) || (op == OP_MUL);

  always_comb begin
    r1 = '0;
    c1 = 1'b0;
    t1 = 1'b0;
    e1 = 1'b0;
    case (op)
      OP_ADD:  {c1, r1} = sum_ab;
      OP_SUB:  begin r1 = diff; c1 = (a >= b); end
      OP_AND:  r1 = a & b;
      OP_OR:   r1 = a | b;
      OP_XOR:  r1 = a ^ b;
      OP_XORR: r1 = {{(W-1){1'b0}}, ^a};
      OP_BEQ:  begin r1 = diff; c1 = (a >= b); t1 = (a == b); end
      OP_BNE:  begin r1 = diff; c1 = (a >= b); t1 = (a != b); end
      OP_BLT:  begin r1 = diff; c1 = (a >= b); t1 = ($signed(a) < $signed(b)); end
      // shift/rotate by zero completes immediately with the operand unchanged
      OP_SRL, OP_SLL, OP_ROL, OP_ROR, OP_MUL: r1 = a;
      default: e1 = 1'b1;
    endcase
  end

  // MUL keeps {hi,lo} as the partial product with the multiplier in lo;
  // shifts/rotates reuse lo as the working value.
  always_comb begin
    step_sum = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
    step_hi  = step_sum[W:1];
    case (cur_op)
      OP_SRL:  step_val = {1'b0, lo[W-1:1]};
      OP_SLL:  step_val = {lo[W-2:0], 1'b0};
      OP_ROL:  step_val = {lo[W-2:0], lo[W-1]};
      OP_ROR:  step_val = {lo[0], lo[W-1:1]};
      default: step_val = {step_sum[0], lo[W-1:1]};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cur_op <= '0;
      lo     <= '0;
      hi     <= '0;
      mcand  <= '0;
      cnt    <= '0;
      result <= '0;
      zero   <= 1'b0;
      carry  <= 1'b0;
      taken  <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cur_op <= op;
            if (op == OP_MUL) begin
              hi    <= '0;
              lo    <= b;
              mcand <= a;
              cnt   <= (SHW+1)'(W);
              state <= BUSY;
            end else if (multi && (b[SHW-1:0] != '0)) begin
              lo    <= a;
              cnt   <= {1'b0, b[SHW-1:0]};
              state <= BUSY;
            end else begin
              result <= r1;
              zero   <= (r1 == '0);
              carry  <= c1;
              taken  <= t1;
              err    <= e1;
              state  <= DONE;
            end
          end
        end
        BUSY: begin
          lo  <= step_val;
          hi  <= step_hi;
          cnt <= cnt - 1'b1;
          if (cnt == (SHW+1)'(1)) begin
            result <= step_val;
            zero   <= (step_val == '0);
            carry  <= (cur_op == OP_MUL) ? (step_hi != '0) :
                      (cur_op == OP_SLL) ? lo[W-1] : 1'b0;
            taken  <= 1'b0;
            err    <= 1'b0;
            state  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign neg       = result[W-1];

endmodule

// File: tb/tb_alu_seq.sv
// Randomized bench for alu_seq with an arithmetic reference model,
// latency, backpressure and mid-operation reset checks.
module tb_alu_seq;
  localparam int W   = 8;
  localparam int SHW = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         zero, neg, carry, taken, err;

  int total = 0;
  int bad   = 0;

  alu_seq #(.W(W), .SHW(SHW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .neg(neg), .carry(carry), .taken(taken),
    .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] r, output logic c, output logic t,
                       output logic e, output int lat);
    int unsigned xi, yi, k, s;
    xi = x; yi = y; k = yi % (1 << SHW);
    r = '0; c = 1'b0; t = 1'b0; e = 1'b0; lat = 1;
    case (o)
      4'd0: begin s = xi + yi; r = W'(s); c = (s >= 256); end
      4'd1: begin r = W'(xi - yi); c = (xi >= yi); end
      4'd2: r = x & y;
      4'd3: r = x | y;
      4'd4: r = x ^ y;
      4'd5: begin r = W'(xi >> k); lat = k + 1; end
      4'd6: begin r = W'(xi << k); c = (k != 0) ? ((xi >> (W - k)) & 1) != 0 : 1'b0; lat = k + 1; end
      4'd7: r = W'(^x);
      4'd8, 4'd9, 4'd10: begin
        r = W'(xi - yi); c = (xi >= yi);
        t = (o == 4'd8) ? (x == y) : (o == 4'd9) ? (x != y) : ($signed(x) < $signed(y));
      end
      4'd11: begin s = xi * yi; r = W'(s); c = (s >> W) != 0; lat = W + 1; end
      4'd12: begin r = W'((xi << k) | (xi >> (W - k))); lat = k + 1; end
      4'd13: begin r = W'((xi >> k) | (xi << (W - k))); lat = k + 1; end
      default: e = 1'b1;
    endcase
  endtask

  task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input int hold);
    logic [W-1:0] er;
    logic ec, et, ee;
    int elat, lat;
    bit seen;
    model(o, x, y, er, ec, et, ee, elat);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    lat = 0; seen = 0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (out_valid) seen = 1;
      else begin
        check("in_ready_busy", in_ready, 0);
        in_valid = 1'($urandom_range(0, 1)); op = 4'($urandom); a = W'($urandom); b = W'($urandom);
      end
    end
    in_valid = 1'b0;
    check("latency", lat, elat);
    check("result", result, er);
    check("zero", zero, (er == '0));
    check("neg", neg, er[W-1]);
    check("carry", carry, ec);
    check("taken", taken, et);
    check("err", err, ee);
    repeat (hold) begin
      in_valid = 1'b1; op = 4'($urandom); a = W'($urandom); b = W'($urandom);
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_ready", in_ready, 0);
      check("hold_result", result, er);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("drain_valid", out_valid, 0);
    check("drain_ready", in_ready, 1);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_result"}, result, 0);
    check({tag, "_flags"}, {zero, neg, carry, taken, err}, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_ready"}, in_ready, 1);
  endtask

  initial begin
    #12;
    check_reset_outs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_op(4'd0, 8'hF0, 8'h20, 0);
    run_op(4'd1, 8'h05, 8'h05, 0);
    run_op(4'd10, 8'hFE, 8'h01, 1);
    run_op(4'd6, 8'h81, 8'h03, 0);
    run_op(4'd13, 8'h01, 8'h01, 0);
    run_op(4'd5, 8'hA5, 8'h00, 0);
    run_op(4'd11, 8'h10, 8'h11, 0);
    run_op(4'd11, 8'h0F, 8'h03, 2);
    run_op(4'd7, 8'h07, 8'h00, 5);
    run_op(4'd6, 8'hFF, 8'h07, 0);
    run_op(4'd12, 8'h81, 8'h0F, 0);
    run_op(4'd8, 8'h33, 8'h33, 0);
    run_op(4'd9, 8'h33, 8'h33, 0);

    // reset in the middle of a multiply
    @(negedge clk);
    in_valid = 1'b1; op = 4'd11; a = 8'hFF; b = 8'hFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outs("midmul");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      check("post_reset_valid", out_valid, 0);
    end
    run_op(4'd14, 8'h12, 8'h34, 0);
    run_op(4'd15, 8'h00, 8'h00, 0);

    for (int i = 0; i < 200; i++) begin
      run_op(4'($urandom_range(0, 15)), W'($urandom), W'($urandom), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, multi-cycle successor to the single-cycle 4-bit-opcode ALU.
- Same opcode encoding 0–10, extended with MUL, ROL and ROR.
- Adds iterative shift/rotate/multiply, a valid/ready handshake on both sides, and registered flags.
- Sits between the register-file read stage and writeback/branch logic; the datapath stalls on `in_ready`/`out_valid`.

Parameters:
- `W`, 8: operand/result width; must be ≥ 2.
- `SHW`, $clog2(W): width of shift/rotate amount taken from `b[SHW-1:0]`.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  operands/op presented.
- `in_ready`  out  1  block can accept; the op is accepted when `in_valid && in_ready`.
- `op`  in  4  opcode:
  - ADD=0, SUB=1, AND=2, OR=3, XOR=4, SRL=5, SLL=6, XORR=7
  - BEQ=8, BNE=9, BLT=10
  - MUL=11, ROL=12, ROR=13
  - 14 and 15 are illegal.
- `a`  in  W  operand A.
- `b`  in  W  operand B (shift amount = `b[SHW-1:0]`).
- `out_valid`  out  1  result/flags valid.
- `out_ready`  in  1  consumer takes the result when `out_valid && out_ready`.
- `result`  out  W  registered result.
- `zero`  out  1  `result == 0`.
- `neg`  out  1  `result[W-1]`.
- `carry`  out  1  carry/no-borrow/overflow (see below).
- `taken`  out  1  branch-condition outcome.
- `err`  out  1  illegal opcode.

Behaviour:
- Reset (async, `rst_n` = 0):
  - State goes to IDLE.
  - `in_ready`=1, `out_valid`=0.
  - `result`, `zero`, `neg`, `carry`, `taken`, `err` all 0.
  - Any in-flight op is discarded.
  - `zero` is held 0 in reset, not derived from `result`.
- FSM states:
  - IDLE: `in_ready`=1.
    - On accept of a single-cycle op (0–4, 7–10, illegal): compute, register outputs, go to DONE.
    - On accept of SRL/SLL/ROL/ROR/MUL: latch operands, go to BUSY.
  - BUSY: `in_ready`=0, `out_valid`=0.
    - Shift/rotate: one bit position per cycle; counter loaded with `b[SHW-1:0]`.
    - MUL: shift-add, one multiplier bit per cycle, exactly W iterations.
    - When the count is exhausted, register outputs and go to DONE.
  - DONE: `out_valid`=1, `in_ready`=0, outputs held stable.
    - On `out_ready`=1: go to IDLE; `out_valid` falls the next cycle.
- Latency, accept edge to `out_valid` high:
  - Single-cycle ops: 1 cycle.
  - Shift/rotate by k: k+1 cycles; k=0 is 1 cycle with `result`=`a`.
  - MUL: W+1 cycles.
  - Minimum spacing between accepts is 2 cycles.
- Arithmetic and width rules (all results W bits, truncated):
  - ADD: `carry` = bit W of the unsigned sum.
  - SUB: `result` = a−b mod 2^W; `carry` = (a ≥ b unsigned), i.e. no borrow.
  - AND/OR/XOR: bitwise; `carry`=0.
  - SRL: logical right, zero fill.
  - SLL: left, zero fill; `carry` = last bit shifted out (0 when k=0).
  - ROL/ROR: rotate by k; `carry`=0.
  - XORR: `result` = {(W-1)'b0, ^a}.
  - MUL: `result` = low W bits of a×b, unsigned; `carry` = 1 iff the high W bits are nonzero.
  - BEQ/BNE/BLT:
    - `result` = a−b; `taken` = (a==b) / (a!=b) / (signed a < signed b) respectively.
    - `taken`=0 for every non-branch op.
  - Illegal op: `result`=0, `err`=1, all other flags 0 except `zero`=1.
- `zero` and `neg` are always derived from the final registered `result`.
- Inputs are ignored while `in_ready`=0. `a`/`b`/`op` changes during BUSY do not affect the op in flight.
- Reset asserted in BUSY or DONE returns to reset values immediately, with no output pulse.

Test Plan:
- W=8, ADD a=0xF0 b=0x20 → 1 cycle later `out_valid`=1, `result`=0x10, `carry`=1, `zero`=0, `taken`=0.
- SUB a=0x05 b=0x05, then BLT a=0xFE b=0x01 → first: `result`=0x00, `zero`=1, `carry`=1; second: `taken`=1 (−2 < 1), `neg`=1.
- SLL a=0x81 b=3 → `out_valid` 4 cycles after accept, `result`=0x08, `carry`=0; ROR a=0x01 b=1 → `result`=0x80; SRL b=0 → 1-cycle latency, `result`=`a`.
- MUL a=0x10 b=0x11 → `out_valid` 9 cycles after accept, `result`=0x10, `carry`=1; MUL 0x0F×0x03 → `result`=0x2D, `carry`=0.
- Backpressure: hold `out_ready`=0 for 5 cycles after XORR a=0x07 → `result`=0x01 held stable, `in_ready`=0 throughout, new `in_valid` ignored; `out_ready`=1 → IDLE, `in_ready`=1 next cycle.
- Pull `rst_n` low mid-MUL (cycle 4) → all outputs 0 asynchronously, `in_ready`=1 after release; op=14 → `err`=1, `result`=0, `zero`=1.
